// File: rtl/wb_boot_loader_if.sv
// ---------------------------------------------------------------------------
// wb_boot_loader_if
//
// Purpose: bundles the Wishbone B3 classic signals between the boot loader
// (master) and the shared program memory (slave).
//
// Signals:
//   wbm_adr_o  32  byte address, master -> slave
//   wbm_dat_o  32  write data, master -> slave
//   wbm_sel_o   4  byte selects, master -> slave
//   wbm_we_o    1  write enable, master -> slave
//   wbm_cyc_o   1  cycle, master -> slave
//   wbm_stb_o   1  strobe, master -> slave
//   wbm_dat_i  32  read data, slave -> master
//   wbm_ack_i   1  acknowledge, slave -> master
//   wbm_err_i   1  bus error, slave -> master
//
// Modports: master (boot loader side), slave (memory side).
// ---------------------------------------------------------------------------
interface wb_boot_loader_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  // Boot loader view: drives the request, receives the termination.
  modport master (
    output wbm_adr_o,
    output wbm_dat_o,
    output wbm_sel_o,
    output wbm_we_o,
    output wbm_cyc_o,
    output wbm_stb_o,
    input  wbm_dat_i,
    input  wbm_ack_i,
    input  wbm_err_i
  );

  // Memory view: receives the request, drives the termination.
  modport slave (
    input  wbm_adr_o,
    input  wbm_dat_o,
    input  wbm_sel_o,
    input  wbm_we_o,
    input  wbm_cyc_o,
    input  wbm_stb_o,
    output wbm_dat_i,
    output wbm_ack_i,
    output wbm_err_i
  );
endinterface

// File: rtl/wb_boot_loader.sv
// ---------------------------------------------------------------------------
// wb_boot_loader
//
// Purpose: Wishbone B3 classic master that copies a program image, one
// 32-bit word at a time, from a synchronous boot-image source into the
// shared program memory starting at BASE_ADDR. The CPU cores are held in
// reset (cpu_rst_o) until the copy finishes successfully.
//
// Parameters:
//   MEM_SIZE     memory size in bytes; a load may be at most MEM_SIZE/4 words
//   BASE_ADDR    byte address of the first destination word (word aligned)
//   ACK_TIMEOUT  cycles a bus access may wait for ack/err before aborting
//
// Ports:
//   wb_clk_i      in   1  clock
//   wb_rst_i      in   1  synchronous active-high reset
//   start_i       in   1  begin a load on its rising edge
//   load_words_i  in  32  number of words to copy, sampled at start
//   src_addr_o    out 32  word index into the image source
//   src_rd_o      out  1  source read strobe, data valid one cycle later
//   src_data_i    in  32  source read data
//   wbm           --   -  Wishbone master bundle (wb_boot_loader_if.master)
//   cpu_rst_o     out  1  holds the cores in reset until the load is done
//   done_o        out  1  load completed successfully
//   err_o         out  1  load aborted
//   err_code_o    out  2  0 none, 1 bus error, 2 timeout, 3 size/verify
//
// Optional feature: define WB_BOOT_LOADER_VERIFY_EN to read every word back
// after it is written and compare it with the value written. Without the
// macro no read cycles are ever issued and wbm_dat_i is ignored.
// ---------------------------------------------------------------------------
module wb_boot_loader #(
  parameter logic [31:0] MEM_SIZE    = 32'h0200_0000,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start_i,
  input  logic [31:0]             load_words_i,
  output logic [31:0]             src_addr_o,
  output logic                    src_rd_o,
  input  logic [31:0]             src_data_i,
  wb_boot_loader_if.master        wbm,
  output logic                    cpu_rst_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;
  localparam logic [2:0] ST_VERIFY = 3'd6;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_BUS_ERR = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_SIZE    = 2'd3;

  localparam logic [31:0] MAX_WORDS = MEM_SIZE >> 2;
  localparam logic [7:0]  TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  logic [2:0]  state;
  logic        start_q;
  logic [31:0] words_n;
  logic [31:0] idx;
  logic [7:0]  tmo_cnt;

  logic [31:0] src_addr_r;
  logic        src_rd_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic [3:0]  sel_r;
  logic        we_r;
  logic        cyc_r;
  logic        stb_r;
  logic        cpu_rst_r;
  logic        done_r;
  logic        err_r;
  logic [1:0]  err_code_r;

  logic        start_rise;
  logic [31:0] idx_next;
  logic        last_word;
  logic [31:0] adr_next;
  logic        tmo_expired;

  // Helper terms shared by several states. start_i is a level, so only a
  // low-to-high change compared with the previous sample launches a load.
  // The destination address wraps naturally at 32 bits. The timeout fires
  // in the last allowed waiting cycle so that cyc stays high for exactly
  // ACK_TIMEOUT cycles before it drops.
  always_comb begin
    start_rise  = start_i & ~start_q;
    idx_next    = idx + 32'd1;
    last_word   = (idx_next == words_n);
    adr_next    = BASE_ADDR + {idx[29:0], 2'b00};
    tmo_expired = (tmo_cnt == TMO_LAST);
  end

  // Main sequencer. Every output is a register updated here. IDLE, DONE and
  // ERROR all accept a new start edge: the edge clears the previous outcome,
  // re-asserts the core reset and immediately runs the size checks, so an
  // empty load goes straight to DONE and an oversized one straight to ERROR
  // without touching the bus. Each word then walks FETCH (source read
  // strobe), LATCH (source data is valid, build the bus request) and WRITE
  // (wait for ack/err/timeout). With verification enabled a write ack turns
  // the still-open cycle into a read of the same address in VERIFY, and the
  // word only counts as copied once the readback matches.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      words_n    <= 32'd0;
      idx        <= 32'd0;
      tmo_cnt    <= 8'd0;
      src_addr_r <= 32'd0;
      src_rd_r   <= 1'b0;
      adr_r      <= 32'd0;
      dat_r      <= 32'd0;
      sel_r      <= 4'h0;
      we_r       <= 1'b0;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= CODE_NONE;
    end else begin
      start_q  <= start_i;
      src_rd_r <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_rise) begin
            words_n    <= load_words_i;
            idx        <= 32'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= CODE_NONE;
            cpu_rst_r  <= 1'b1;
            if (load_words_i == 32'd0) begin
              state     <= ST_DONE;
              done_r    <= 1'b1;
              cpu_rst_r <= 1'b0;
            end else if (load_words_i > MAX_WORDS) begin
              state      <= ST_ERROR;
              err_r      <= 1'b1;
              err_code_r <= CODE_SIZE;
            end else begin
              state      <= ST_FETCH;
              src_rd_r   <= 1'b1;
              src_addr_r <= 32'd0;
            end
          end
        end

        ST_FETCH: begin
          state <= ST_LATCH;
        end

        ST_LATCH: begin
          dat_r   <= src_data_i;
          adr_r   <= adr_next;
          sel_r   <= 4'hF;
          we_r    <= 1'b1;
          cyc_r   <= 1'b1;
          stb_r   <= 1'b1;
          tmo_cnt <= 8'd0;
          state   <= ST_WRITE;
        end

        ST_WRITE: begin
          if (wbm.wbm_err_i) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            state      <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= CODE_BUS_ERR;
          end else if (wbm.wbm_ack_i) begin
`ifdef WB_BOOT_LOADER_VERIFY_EN
            we_r    <= 1'b0;
            tmo_cnt <= 8'd0;
            state   <= ST_VERIFY;
`else
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            we_r  <= 1'b0;
            sel_r <= 4'h0;
            idx   <= idx_next;
            if (last_word) begin
              state     <= ST_DONE;
              done_r    <= 1'b1;
              cpu_rst_r <= 1'b0;
            end else begin
              state      <= ST_FETCH;
              src_rd_r   <= 1'b1;
              src_addr_r <= idx_next;
            end
`endif
          end else if (tmo_expired) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            state      <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= CODE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

`ifdef WB_BOOT_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (wbm.wbm_err_i) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            sel_r      <= 4'h0;
            state      <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= CODE_BUS_ERR;
          end else if (wbm.wbm_ack_i) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            sel_r <= 4'h0;
            if (wbm.wbm_dat_i != dat_r) begin
              state      <= ST_ERROR;
              err_r      <= 1'b1;
              err_code_r <= CODE_SIZE;
            end else begin
              idx <= idx_next;
              if (last_word) begin
                state     <= ST_DONE;
                done_r    <= 1'b1;
                cpu_rst_r <= 1'b0;
              end else begin
                state      <= ST_FETCH;
                src_rd_r   <= 1'b1;
                src_addr_r <= idx_next;
              end
            end
          end else if (tmo_expired) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            sel_r      <= 4'h0;
            state      <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= CODE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          cyc_r <= 1'b0;
          stb_r <= 1'b0;
          we_r  <= 1'b0;
          sel_r <= 4'h0;
        end
      endcase
    end
  end

  // Registered state drives the ports and the Wishbone bundle directly.
  assign src_addr_o    = src_addr_r;
  assign src_rd_o      = src_rd_r;
  assign wbm.wbm_adr_o = adr_r;
  assign wbm.wbm_dat_o = dat_r;
  assign wbm.wbm_sel_o = sel_r;
  assign wbm.wbm_we_o  = we_r;
  assign wbm.wbm_cyc_o = cyc_r;
  assign wbm.wbm_stb_o = stb_r;
  assign cpu_rst_o     = cpu_rst_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign err_code_o    = err_code_r;

endmodule

// File: tb/tb_wb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_wb_boot_loader
//
// Purpose: self-checking bench for wb_boot_loader. Expected memory writes are
// queued when a load is launched; a monitor pops and compares them whenever
// the DUT completes a write on the bus. Status outputs and cycle counts are
// compared against hand-computed values after each load.
// ---------------------------------------------------------------------------
module tb_wb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

`ifdef WB_BOOT_LOADER_VERIFY_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 3;
`endif

  localparam int MODE_NORMAL  = 0;
  localparam int MODE_ERR_W2  = 1;
  localparam int MODE_HANG    = 2;
  localparam int MODE_CORRUPT = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        wb_rst_i;
  logic        start_i;
  logic [31:0] load_words_i;
  logic [31:0] src_addr_o;
  logic        src_rd_o;
  logic [31:0] src_data_i;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int   checks;
  int   errors;
  int   slave_mode;
  int   cyc_cycles;
  int   write_terms;
  int   read_terms;
  exp_t exp_q[$];

  logic [31:0] image_tbl [0:7] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h55555555, 32'h66666666,
                                   32'h77777777, 32'h88888888};
  logic [31:0] mem [0:7];

  wb_boot_loader_if wb ();

  wb_boot_loader dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .start_i      (start_i),
    .load_words_i (load_words_i),
    .src_addr_o   (src_addr_o),
    .src_rd_o     (src_rd_o),
    .src_data_i   (src_data_i),
    .wbm          (wb),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous image source: returns the addressed word one cycle after
  // the read strobe.
  always_ff @(posedge clk) begin
    if (src_rd_o) src_data_i <= image_tbl[src_addr_o[2:0]];
  end

  // Zero-wait memory model. The mode selects an injected fault: a bus error
  // on the write to 0x8, never terminating, or corrupting the readback of 0x4.
  always_comb begin
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    wb.wbm_dat_i = mem[wb.wbm_adr_o[4:2]];
    if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
      if (slave_mode == MODE_ERR_W2 && wb.wbm_we_o && wb.wbm_adr_o == 32'h8)
        wb.wbm_err_i = 1'b1;
      else if (slave_mode != MODE_HANG)
        wb.wbm_ack_i = 1'b1;
    end
    if (slave_mode == MODE_CORRUPT && wb.wbm_adr_o == 32'h4)
      wb.wbm_dat_i = mem[1] ^ 32'h0000_0001;
  end

  // Memory contents so readback returns what was written.
  always_ff @(posedge clk) begin
    if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_we_o && wb.wbm_ack_i)
      mem[wb.wbm_adr_o[4:2]] <= wb.wbm_dat_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts bus activity and checks every completed write against
  // the head of the expected-write queue.
  initial begin
    exp_t e;
    cyc_cycles  = 0;
    write_terms = 0;
    read_terms  = 0;
    forever begin
      @(negedge clk);
      if (wb.wbm_cyc_o) cyc_cycles++;
      if (wb.wbm_cyc_o && wb.wbm_stb_o && (wb.wbm_ack_i || wb.wbm_err_i)) begin
        if (wb.wbm_we_o) write_terms++;
        else read_terms++;
      end
      if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_we_o && wb.wbm_ack_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h, expected none",
                   wb.wbm_adr_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", wb.wbm_adr_o, e.addr);
          checkOutput("wr_data", wb.wbm_dat_o, e.data);
          checkOutput("wr_sel", {28'd0, wb.wbm_sel_o}, 32'hF);
        end
      end
    end
  end

  // Queue the writes expected to be acked, then raise start for one edge.
  task automatic applyStimulus(input logic [31:0] n, input int mode,
                               input int push_count);
    @(negedge clk);
    slave_mode = mode;
    for (int i = 0; i < push_count; i++)
      exp_q.push_back('{addr: BASE + 32'(4 * i), data: image_tbl[i]});
    load_words_i = n;
    start_i      = 1'b1;
    @(posedge clk);
  endtask

  // Edges after the start edge until done/err; an expired budget is a failure.
  task automatic waitOutcome(input int budget, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!(done_o || err_o) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!(done_o || err_o)) begin
      checks++;
      errors++;
      $display("[TB] FAIL outcome_timeout: got no done/err, expected one within %0d", budget);
    end
    start_i = 1'b0;
  endtask

  initial begin
    int cyc_before;
    int wr_before;
    int rd_before;
    int lat;

    checks       = 0;
    errors       = 0;
    slave_mode   = MODE_NORMAL;
    wb_rst_i     = 1'b1;
    start_i      = 1'b0;
    load_words_i = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_code", {30'd0, err_code_o}, 32'd0);
    checkOutput("rst_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    checkOutput("rst_src_rd", {31'd0, src_rd_o}, 32'd0);
    wb_rst_i = 1'b0;

    $display("[TB] load of 4 words");
    wr_before = write_terms;
    applyStimulus(32'd4, MODE_NORMAL, 4);
    waitOutcome(100, lat);
    checkOutput("n4_latency", 32'(lat), 32'(4 * CPW));
    checkOutput("n4_done", {31'd0, done_o}, 32'd1);
    checkOutput("n4_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    checkOutput("n4_err", {31'd0, err_o}, 32'd0);
    checkOutput("n4_writes", 32'(write_terms - wr_before), 32'd4);
    checkOutput("n4_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] oversize load");
    cyc_before = cyc_cycles;
    applyStimulus(32'h0080_0001, MODE_NORMAL, 0);
    waitOutcome(20, lat);
    checkOutput("big_latency", 32'(lat), 32'd0);
    checkOutput("big_err", {31'd0, err_o}, 32'd1);
    checkOutput("big_code", {30'd0, err_code_o}, 32'd3);
    checkOutput("big_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("big_done", {31'd0, done_o}, 32'd0);
    checkOutput("big_no_cyc", 32'(cyc_cycles - cyc_before), 32'd0);

    $display("[TB] empty load");
    cyc_before = cyc_cycles;
    applyStimulus(32'd0, MODE_NORMAL, 0);
    waitOutcome(20, lat);
    checkOutput("n0_latency", 32'(lat), 32'd0);
    checkOutput("n0_done", {31'd0, done_o}, 32'd1);
    checkOutput("n0_err", {31'd0, err_o}, 32'd0);
    checkOutput("n0_code", {30'd0, err_code_o}, 32'd0);
    checkOutput("n0_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    checkOutput("n0_no_cyc", 32'(cyc_cycles - cyc_before), 32'd0);

    $display("[TB] bus error on word 2 of 5");
    wr_before = write_terms;
    applyStimulus(32'd5, MODE_ERR_W2, 2);
    waitOutcome(100, lat);
    checkOutput("berr_err", {31'd0, err_o}, 32'd1);
    checkOutput("berr_code", {30'd0, err_code_o}, 32'd1);
    checkOutput("berr_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("berr_done", {31'd0, done_o}, 32'd0);
    checkOutput("berr_writes", 32'(write_terms - wr_before), 32'd3);
    checkOutput("berr_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] retry of 5 words with good slave");
    wr_before = write_terms;
    applyStimulus(32'd5, MODE_NORMAL, 5);
    waitOutcome(100, lat);
    checkOutput("n5_latency", 32'(lat), 32'(5 * CPW));
    checkOutput("n5_done", {31'd0, done_o}, 32'd1);
    checkOutput("n5_err", {31'd0, err_o}, 32'd0);
    checkOutput("n5_code", {30'd0, err_code_o}, 32'd0);
    checkOutput("n5_writes", 32'(write_terms - wr_before), 32'd5);
    checkOutput("n5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] ack timeout");
    cyc_before = cyc_cycles;
    applyStimulus(32'd1, MODE_HANG, 0);
    waitOutcome(400, lat);
    checkOutput("tmo_cyc_cycles", 32'(cyc_cycles - cyc_before), 32'd255);
    checkOutput("tmo_err", {31'd0, err_o}, 32'd1);
    checkOutput("tmo_code", {30'd0, err_code_o}, 32'd2);
    checkOutput("tmo_cyc_low", {31'd0, wb.wbm_cyc_o}, 32'd0);
    checkOutput("tmo_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);

    $display("[TB] reset during stalled write");
    applyStimulus(32'd2, MODE_HANG, 0);
    for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checkOutput("mid_cyc_before", {31'd0, wb.wbm_cyc_o}, 32'd1);
    wb_rst_i = 1'b1;
    start_i  = 1'b0;
    @(negedge clk);
    checkOutput("mid_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    checkOutput("mid_stb", {31'd0, wb.wbm_stb_o}, 32'd0);
    checkOutput("mid_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("mid_done", {31'd0, done_o}, 32'd0);
    checkOutput("mid_err", {31'd0, err_o}, 32'd0);
    wb_rst_i   = 1'b0;
    slave_mode = MODE_NORMAL;

`ifdef WB_BOOT_LOADER_VERIFY_EN
    $display("[TB] readback corruption on word 1");
    wr_before = write_terms;
    rd_before = read_terms;
    applyStimulus(32'd4, MODE_CORRUPT, 2);
    waitOutcome(100, lat);
    checkOutput("ver_err", {31'd0, err_o}, 32'd1);
    checkOutput("ver_code", {30'd0, err_code_o}, 32'd3);
    checkOutput("ver_writes", 32'(write_terms - wr_before), 32'd2);
    checkOutput("ver_reads", 32'(read_terms - rd_before), 32'd2);
    checkOutput("ver_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    rd_before = read_terms;
    checkOutput("no_read_cycles", 32'(rd_before), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
